// File: rtl/ctrl_pkg.sv
// ctrl_pkg: opcode, ALU-op encodings and the control bundle shared by the decode stage.
package ctrl_pkg;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] ALU_OR    = 2'b11;
  typedef struct packed {
    logic [1:0] alu_op;
    logic       reg_dst;
    logic       alu_src;
    logic       mem_wr;
    logic       mem_to_reg;
    logic       reg_wr;
    logic       ext_op;
    logic       branch;
    logic       bne;
    logic       illegal;
  } ctrl_t;
endpackage

// File: rtl/ctrl_decode_comb.sv
// ctrl_decode_comb: combinational opcode-to-control table plus the rt-operand usage flag.
module ctrl_decode_comb
  import ctrl_pkg::*;
#(
  parameter bit ORI_EN = 1'b1
) (
  input  logic [5:0] i_opcode,
  output ctrl_t      o_ctrl,
  output logic       o_uses_rt
);
  always_comb begin
    o_ctrl = '0;
    case (i_opcode)
      OP_RTYPE: o_ctrl = '{alu_op: ALU_FUNCT, reg_dst: 1'b1, reg_wr: 1'b1, ext_op: 1'b1, default: 1'b0};
      OP_LW:    o_ctrl = '{alu_op: ALU_ADD, alu_src: 1'b1, mem_to_reg: 1'b1, reg_wr: 1'b1, ext_op: 1'b1, default: 1'b0};
      OP_SW:    o_ctrl = '{alu_op: ALU_ADD, alu_src: 1'b1, mem_wr: 1'b1, ext_op: 1'b1, default: 1'b0};
      OP_ADDI:  o_ctrl = '{alu_op: ALU_ADD, alu_src: 1'b1, reg_wr: 1'b1, ext_op: 1'b1, default: 1'b0};
      OP_BEQ:   o_ctrl = '{alu_op: ALU_SUB, branch: 1'b1, default: 1'b0};
      OP_BNE:   o_ctrl = '{alu_op: ALU_SUB, branch: 1'b1, bne: 1'b1, default: 1'b0};
      OP_ORI:   o_ctrl = ORI_EN ? '{alu_op: ALU_OR, alu_src: 1'b1, reg_wr: 1'b1, default: 1'b0}
                                : '{illegal: 1'b1, default: 1'b0};
      default:  o_ctrl = '{illegal: 1'b1, default: 1'b0};
    endcase
  end
  assign o_uses_rt = i_opcode inside {OP_RTYPE, OP_SW, OP_BEQ, OP_BNE};
endmodule

// File: rtl/ctrl_decode_pipe.sv
// ctrl_decode_pipe: registered ID/EX decode stage with valid/ready handshake,
// load-use bubble insertion, branch flush and a saturating bubble counter.
module ctrl_decode_pipe
  import ctrl_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter bit ORI_EN = 1'b1,
  parameter bit HAZ_EN = 1'b1,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [31:0]       in_inst,
  output logic              in_ready,
  input  logic              flush,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [1:0]        alu_op,
  output logic              reg_dst,
  output logic              alu_src,
  output logic              mem_wr,
  output logic              mem_to_reg,
  output logic              reg_wr,
  output logic              ext_op,
  output logic              branch,
  output logic              bne,
  output logic              illegal,
  output logic [5:0]        opcode,
  output logic [5:0]        func,
  output logic [4:0]        shamt,
  output logic [REG_AW-1:0] rs,
  output logic [REG_AW-1:0] rt,
  output logic [REG_AW-1:0] rd,
  output logic [15:0]       imm,
  output logic [CNT_W-1:0]  haz_cnt
);
  ctrl_t             w_dec, r_ctrl;
  logic              w_uses_rt, w_load, w_hazard, r_valid;
  logic [REG_AW-1:0] w_in_rs, w_in_rt, r_rs, r_rt, r_rd;
  logic [5:0]        r_opcode, r_func;
  logic [4:0]        r_shamt;
  logic [15:0]       r_imm;
  logic [CNT_W-1:0]  r_cnt;
  ctrl_decode_comb #(.ORI_EN(ORI_EN)) u_dec (
    .i_opcode (in_inst[31:26]),
    .o_ctrl   (w_dec),
    .o_uses_rt(w_uses_rt)
  );
  assign w_in_rs  = REG_AW'(in_inst[25:21]);
  assign w_in_rt  = REG_AW'(in_inst[20:16]);
  assign w_load   = ~r_valid | out_ready;
  // A load still in ID/EX whose destination the incoming instruction reads forces one bubble.
  assign w_hazard = HAZ_EN & in_valid & r_valid & r_ctrl.mem_to_reg & (r_rt != '0) &
                    ((w_in_rs == r_rt) | (w_uses_rt & (w_in_rt == r_rt)));
  assign in_ready = w_load & ~w_hazard & ~flush;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid  <= 1'b0;
      r_ctrl   <= '0;
      r_opcode <= '0;
      r_func   <= '0;
      r_shamt  <= '0;
      r_rs     <= '0;
      r_rt     <= '0;
      r_rd     <= '0;
      r_imm    <= '0;
      r_cnt    <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_load) begin
      r_valid <= in_valid & ~w_hazard;
      if (w_hazard) begin
        r_cnt <= r_cnt + CNT_W'(r_cnt != '1);
      end else if (in_valid) begin
        r_ctrl   <= w_dec;
        r_opcode <= in_inst[31:26];
        r_func   <= in_inst[5:0];
        r_shamt  <= in_inst[10:6];
        r_rs     <= w_in_rs;
        r_rt     <= w_in_rt;
        r_rd     <= REG_AW'(in_inst[15:11]);
        r_imm    <= in_inst[15:0];
      end
    end
  end
  assign out_valid  = r_valid;
  assign alu_op     = r_ctrl.alu_op;
  assign reg_dst    = r_ctrl.reg_dst;
  assign alu_src    = r_ctrl.alu_src;
  assign mem_wr     = r_ctrl.mem_wr;
  assign mem_to_reg = r_ctrl.mem_to_reg;
  assign reg_wr     = r_ctrl.reg_wr;
  assign ext_op     = r_ctrl.ext_op;
  assign branch     = r_ctrl.branch;
  assign bne        = r_ctrl.bne;
  assign illegal    = r_ctrl.illegal;
  assign opcode     = r_opcode;
  assign func       = r_func;
  assign shamt      = r_shamt;
  assign rs         = r_rs;
  assign rt         = r_rt;
  assign rd         = r_rd;
  assign imm        = r_imm;
  assign haz_cnt    = r_cnt;
endmodule
